// File: rtl/rst_sequencer.sv
// rst_sequencer: releases downstream domains clock-first then reset, in ascending order,
// and re-resets them all after a quiesce handshake when software asks.
module rst_sequencer #(
  parameter int NUM_DOMAINS     = 3,
  parameter int STAGE_DELAY     = 4,
  parameter int QUIESCE_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   sw_rst_req_i,
  output logic                   sw_rst_ack_o,
  output logic                   quiesce_req_o,
  input  logic                   quiesce_ack_i,
  output logic [NUM_DOMAINS-1:0] clk_en_o,
  output logic [NUM_DOMAINS-1:0] rstn_o,
  output logic                   done_o,
  output logic                   timeout_o
);
  localparam int KW = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [7:0] DLY = 8'(STAGE_DELAY - 1);
  localparam logic [15:0] QLIM = 16'(QUIESCE_TIMEOUT - 1);
  localparam logic [KW-1:0] KLAST = KW'(NUM_DOMAINS - 1);
  typedef enum logic [2:0] {IDLE_RST, CLK_ON, RST_OFF, RUN, QUIESCE, RST_ON, CLK_OFF} state_e;
  state_e                 state_q;
  logic [7:0]             dly_q;
  logic [15:0]            qcnt_q;
  logic [KW-1:0]          k_q, k_d;
  logic [NUM_DOMAINS-1:0] clk_en_q, rstn_q, mask_k, mask_d;
  logic                   done_q, qreq_q, ack_q, tmo_q;
  assign k_d    = k_q + KW'(1);
  assign mask_k = NUM_DOMAINS'(1) << k_q;
  assign mask_d = NUM_DOMAINS'(1) << k_d;
  // Outputs are set on the transition edge so every one comes straight from a flop.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE_RST;
      dly_q    <= '0;
      qcnt_q   <= '0;
      k_q      <= '0;
      clk_en_q <= '0;
      rstn_q   <= '0;
      done_q   <= 1'b0;
      qreq_q   <= 1'b0;
      ack_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      dly_q <= dly_q - {7'd0, |dly_q};
      case (state_q)
        IDLE_RST: begin
          state_q  <= CLK_ON;
          k_q      <= '0;
          clk_en_q <= clk_en_q | NUM_DOMAINS'(1);
          dly_q    <= DLY;
        end
        CLK_ON: if (dly_q == 8'd0) begin
          state_q <= RST_OFF;
          rstn_q  <= rstn_q | mask_k;
          dly_q   <= DLY;
        end
        RST_OFF: if (dly_q == 8'd0) begin
          if (k_q == KLAST) begin
            state_q <= RUN;
            done_q  <= 1'b1;
          end else begin
            state_q  <= CLK_ON;
            k_q      <= k_d;
            clk_en_q <= clk_en_q | mask_d;
            dly_q    <= DLY;
          end
        end
        RUN: if (sw_rst_req_i) begin
          state_q <= QUIESCE;
          done_q  <= 1'b0;
          qreq_q  <= 1'b1;
          qcnt_q  <= '0;
        end
        QUIESCE: begin
          // An ack arriving on the timeout cycle wins, so the flag is only set for a real stall.
          if (quiesce_ack_i || qcnt_q == QLIM) begin
            state_q <= RST_ON;
            qreq_q  <= 1'b0;
            rstn_q  <= '0;
            dly_q   <= DLY;
            tmo_q   <= tmo_q | ~quiesce_ack_i;
          end else begin
            qcnt_q <= qcnt_q + 16'd1;
          end
        end
        RST_ON: if (dly_q == 8'd0) begin
          state_q  <= CLK_OFF;
          clk_en_q <= '0;
          dly_q    <= DLY;
        end
        CLK_OFF: if (dly_q == 8'd0) begin
          state_q  <= CLK_ON;
          ack_q    <= 1'b1;
          k_q      <= '0;
          clk_en_q <= NUM_DOMAINS'(1);
          dly_q    <= DLY;
        end
        default: state_q <= IDLE_RST;
      endcase
    end
  end
  assign sw_rst_ack_o  = ack_q;
  assign quiesce_req_o = qreq_q;
  assign clk_en_o      = clk_en_q;
  assign rstn_o        = rstn_q;
  assign done_o        = done_q;
  assign timeout_o     = tmo_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: segment table of per-cycle inputs/expected outputs for two configurations,
// checked through an expected-value queue one cycle after each drive.
module tb_rst_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rn_a = 1'b0, rq_a = 1'b0, ak_a = 1'b0, sa_a, qr_a, dn_a, to_a;
  logic [2:0] ce_a, rs_a;
  logic rn_b = 1'b0, rq_b = 1'b0, ak_b = 1'b0, sa_b, qr_b, dn_b, to_b;
  logic [0:0] ce_b, rs_b;
  rst_sequencer #(.NUM_DOMAINS(3), .STAGE_DELAY(4), .QUIESCE_TIMEOUT(10)) u_a (
    .clk_i(clk), .rstn_i(rn_a), .sw_rst_req_i(rq_a), .sw_rst_ack_o(sa_a),
    .quiesce_req_o(qr_a), .quiesce_ack_i(ak_a), .clk_en_o(ce_a), .rstn_o(rs_a),
    .done_o(dn_a), .timeout_o(to_a));
  rst_sequencer #(.NUM_DOMAINS(1), .STAGE_DELAY(2)) u_b (
    .clk_i(clk), .rstn_i(rn_b), .sw_rst_req_i(rq_b), .sw_rst_ack_o(sa_b),
    .quiesce_req_o(qr_b), .quiesce_ack_i(ak_b), .clk_en_o(ce_b), .rstn_o(rs_b),
    .done_o(dn_b), .timeout_o(to_b));
  typedef struct {
    logic       d;
    int         n;
    logic       rn, rq, ak;
    logic [2:0] ce, rs;
    logic       dn, qr, sa, to;
  } seg_t;
  seg_t tbl[$];
  logic [9:0] exp_q[$];
  int checks = 0, fails = 0;
  function automatic void add(input logic d, input int n, input logic rn, input logic rq,
                              input logic ak, input logic [2:0] ce, input logic [2:0] rs,
                              input logic dn, input logic qr, input logic sa, input logic to);
    seg_t s;
    s.d = d; s.n = n; s.rn = rn; s.rq = rq; s.ak = ak; s.ce = ce; s.rs = rs;
    s.dn = dn; s.qr = qr; s.sa = sa; s.to = to;
    tbl.push_back(s);
  endfunction
  // Ascending clock-then-reset release for the 3-domain instance, ending just before RUN.
  function automatic void rel(input logic rq, input logic to, input logic swack);
    if (swack) begin
      add(0, 1, 1, rq, 0, 3'b001, 3'b000, 0, 0, 1, to);
      add(0, 3, 1, rq, 0, 3'b001, 3'b000, 0, 0, 0, to);
    end else add(0, 4, 1, rq, 0, 3'b001, 3'b000, 0, 0, 0, to);
    add(0, 4, 1, rq, 0, 3'b001, 3'b001, 0, 0, 0, to);
    add(0, 4, 1, rq, 0, 3'b011, 3'b001, 0, 0, 0, to);
    add(0, 4, 1, rq, 0, 3'b011, 3'b011, 0, 0, 0, to);
    add(0, 4, 1, rq, 0, 3'b111, 3'b011, 0, 0, 0, to);
    add(0, 4, 1, rq, 0, 3'b111, 3'b111, 0, 0, 0, to);
  endfunction
  // Quiesce already acked/timed out: RST_ON for 4 cycles, CLK_OFF for 4 cycles.
  function automatic void tear(input logic to);
    add(0, 3, 1, 0, 0, 3'b111, 3'b000, 0, 0, 0, to);
    add(0, 4, 1, 0, 0, 3'b000, 3'b000, 0, 0, 0, to);
  endfunction
  initial begin
    seg_t s;
    logic [9:0] act, e;
    add(0, 3, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    rel(0, 0, 0);
    add(0, 2, 1, 0, 0, 3'b111, 3'b111, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0, 3'b111, 3'b111, 0, 1, 0, 0);
    add(0, 2, 1, 0, 0, 3'b111, 3'b111, 0, 1, 0, 0);
    add(0, 1, 1, 0, 1, 3'b111, 3'b000, 0, 0, 0, 0);
    tear(0);
    rel(0, 0, 1);
    add(0, 2, 1, 0, 0, 3'b111, 3'b111, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0, 3'b111, 3'b111, 0, 1, 0, 0);
    add(0, 9, 1, 0, 0, 3'b111, 3'b111, 0, 1, 0, 0);
    add(0, 1, 1, 0, 1, 3'b111, 3'b000, 0, 0, 0, 0);
    tear(0);
    rel(0, 0, 1);
    add(0, 2, 1, 0, 0, 3'b111, 3'b111, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0, 3'b111, 3'b111, 0, 1, 0, 0);
    add(0, 9, 1, 0, 0, 3'b111, 3'b111, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 3'b111, 3'b000, 0, 0, 0, 1);
    tear(1);
    rel(0, 1, 1);
    add(0, 2, 1, 0, 0, 3'b111, 3'b111, 1, 0, 0, 1);
    add(0, 1, 1, 1, 0, 3'b111, 3'b111, 0, 1, 0, 1);
    add(0, 1, 1, 0, 1, 3'b111, 3'b000, 0, 0, 0, 1);
    tear(1);
    add(0, 1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 1, 1);
    add(0, 3, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0, 1);
    add(0, 4, 1, 0, 0, 3'b001, 3'b001, 0, 0, 0, 1);
    add(0, 4, 1, 0, 0, 3'b011, 3'b001, 0, 0, 0, 1);
    add(0, 2, 1, 0, 0, 3'b011, 3'b011, 0, 0, 0, 1);
    add(0, 2, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    rel(1, 0, 0);
    add(0, 1, 1, 1, 0, 3'b111, 3'b111, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0, 3'b111, 3'b111, 0, 1, 0, 0);
    add(0, 1, 1, 0, 1, 3'b111, 3'b000, 0, 0, 0, 0);
    tear(0);
    add(1, 2, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    add(1, 2, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0);
    add(1, 2, 1, 0, 0, 3'b001, 3'b001, 0, 0, 0, 0);
    add(1, 2, 1, 0, 0, 3'b001, 3'b001, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 3'b001, 3'b001, 0, 1, 0, 0);
    add(1, 2, 1, 0, 1, 3'b001, 3'b000, 0, 0, 0, 0);
    add(1, 2, 1, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 3'b001, 3'b000, 0, 0, 0, 0);
    add(1, 2, 1, 0, 0, 3'b001, 3'b001, 0, 0, 0, 0);
    add(1, 2, 1, 0, 0, 3'b001, 3'b001, 1, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      s = tbl[i];
      for (int c = 0; c < s.n; c++) begin
        @(negedge clk);
        if (s.d) begin rn_b = s.rn; rq_b = s.rq; ak_b = s.ak; end
        else begin rn_a = s.rn; rq_a = s.rq; ak_a = s.ak; end
        exp_q.push_back({s.ce, s.rs, s.dn, s.qr, s.sa, s.to});
        @(posedge clk);
        #1;
        act = s.d ? {2'b00, ce_b, 2'b00, rs_b, dn_b, qr_b, sa_b, to_b}
                  : {ce_a, rs_a, dn_a, qr_a, sa_a, to_a};
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          fails++;
          $display("FAIL outputs dut%0d seg%0d cyc%0d: got ce=%b rs=%b dn/qr/sa/to=%b want ce=%b rs=%b dn/qr/sa/to=%b",
                   s.d, i, c, act[9:7], act[6:4], act[3:0], e[9:7], e[6:4], e[3:0]);
        end
        checks++;
        if (((rs_a & ~ce_a) !== 3'b000) || ((rs_b & ~ce_b) !== 1'b0)) begin
          fails++;
          $display("FAIL order seg%0d cyc%0d: got a rs=%b ce=%b b rs=%b ce=%b want no reset released without clock",
                   i, c, rs_a, ce_a, rs_b, ce_b);
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 3, number of sequenced downstream domains (1..8).
REQ-002 SHALL have parameter STAGE_DELAY, default 4, cycles between sequencing steps (2..255).
REQ-003 SHALL have parameter QUIESCE_TIMEOUT, default 255, maximum cycles to wait for quiesce_ack_i (1..65535).
REQ-004 SHALL have port clk_i, input, 1, single clock, already synchronised root clock.
REQ-005 SHALL have port rstn_i, input, 1, synchronous active-low reset, already synchronised root reset.
REQ-006 SHALL have port sw_rst_req_i, input, 1, level request to re-reset all domains.
REQ-007 SHALL have port sw_rst_ack_o, output, 1, one-cycle pulse when a software reset completes.
REQ-008 SHALL have port quiesce_req_o, output, 1, asks domains to drain before reset.
REQ-009 SHALL have port quiesce_ack_i, input, 1, domains idle.
REQ-010 SHALL have port clk_en_o, output, NUM_DOMAINS, per-domain clock-gate enable.
REQ-011 SHALL have port rstn_o, output, NUM_DOMAINS, per-domain active-low reset.
REQ-012 SHALL have port done_o, output, 1, all domains out of reset.
REQ-013 SHALL have port timeout_o, output, 1, sticky flag, quiesce timed out.

Function
REQ-014 SHALL implement FSM states IDLE_RST, CLK_ON, RST_OFF, RUN, QUIESCE, RST_ON, CLK_OFF.
REQ-015 SHALL use one delay counter, 8 bits, loaded with STAGE_DELAY-1 on state entry; a step completes when the counter is 0.
REQ-016 SHALL leave IDLE_RST for CLK_ON with domain index k=0 on the first cycle after rstn_i is high.
REQ-017 In CLK_ON, SHALL set clk_en_o[k]=1 on entry; after STAGE_DELAY cycles, SHALL go to RST_OFF.
REQ-018 In RST_OFF, SHALL set rstn_o[k]=1 on entry; after STAGE_DELAY cycles, SHALL go to CLK_ON with k+1, or to RUN if k==NUM_DOMAINS-1.
REQ-019 SHALL release domains strictly in ascending index order; rstn_o[j] SHALL never be 1 while clk_en_o[j] is 0.
REQ-020 In RUN, SHALL drive done_o=1, with all clk_en_o and all rstn_o bits at 1.
REQ-021 In RUN, SHALL go to QUIESCE when sw_rst_req_i=1; sw_rst_req_i SHALL be ignored in all other states.
REQ-022 In QUIESCE, SHALL hold quiesce_req_o=1 and done_o=0; on quiesce_ack_i=1, SHALL go to RST_ON on the next cycle.
REQ-023 In QUIESCE, SHALL count cycles from 0; at QUIESCE_TIMEOUT cycles without ack, SHALL set timeout_o=1 and go to RST_ON.
REQ-024 If quiesce_ack_i rises on the timeout cycle, SHALL treat it as acked and leave timeout_o unchanged.
REQ-025 In RST_ON, SHALL drive all rstn_o bits to 0 simultaneously with clocks still enabled, and deassert quiesce_req_o.
REQ-026 SHALL go from RST_ON to CLK_OFF after STAGE_DELAY cycles.
REQ-027 In CLK_OFF, SHALL drive all clk_en_o bits to 0; after STAGE_DELAY cycles, SHALL pulse sw_rst_ack_o for one cycle and go to CLK_ON with k=0.
REQ-028 timeout_o SHALL clear only on rstn_i; it SHALL NOT be cleared by a software reset.
REQ-029 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-030 When rstn_i=0 at a clk_i edge, SHALL enter IDLE_RST in any state, including mid-sequence.
REQ-031 Reset values SHALL be: clk_en_o=0, rstn_o=0, done_o=0, quiesce_req_o=0, sw_rst_ack_o=0, timeout_o=0, k=0, counters=0.
REQ-032 SHALL NOT use an asynchronous reset on any flop.

Verification
REQ-033 Power-up with defaults, rstn_i rising at cycle 0: clk_en_o[0] at cycle 1, rstn_o[0] at cycle 5, clk_en_o[1] at 9, rstn_o[1] at 13, clk_en_o[2] at 17, rstn_o[2] at 21, done_o at 25.
REQ-034 In RUN, pulse sw_rst_req_i and return quiesce_ack_i 3 cycles after quiesce_req_o rises: rstn_o=000, then clk_en_o=000 4 cycles later, sw_rst_ack_o pulse, re-release as in REQ-033, timeout_o=0.
REQ-035 With QUIESCE_TIMEOUT=10 and quiesce_ack_i held at 0: after 10 cycles timeout_o=1, reset proceeds, and timeout_o stays 1 after done_o returns.
REQ-036 Drop rstn_i while in RST_OFF for k=1: next cycle all outputs equal their reset values; after rstn_i rises, the sequence restarts from k=0.
REQ-037 Hold sw_rst_req_i=1 during the power-up sequence: no QUIESCE before done_o; QUIESCE is entered the cycle after RUN.
REQ-038 NUM_DOMAINS=1, STAGE_DELAY=2: rstn_o[0] 2 cycles after clk_en_o[0], done_o 2 cycles later, and rstn_o[j]=1 with clk_en_o[j]=0 never occurs.
